btb: RTL and testbench

BTB -- requirements
Module: btb

---
 rtl/btb.sv | 183 ++++++++++++++++++
 tb/tb_btb.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/btb.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : btb (with btb_pkg)
//  Brief    : Direct-mapped branch target buffer with a 2-bit direction
//             counter per entry and a one-entry-per-cycle flush sweep.
//  Revision : 1.0
// ============================================================================

package btb_pkg;
    typedef struct packed {
        logic [63:0] pc;
        logic [63:0] target_address;
        logic        is_taken;
        logic        valid;
        logic        is_mispredict;
        logic        is_lower_16;
        logic        clear;
    } branchpredict_t;
endpackage

module btb
    import btb_pkg::*;
#(
    parameter int NR_ENTRIES = 64,
    parameter int TAG_BITS   = 16
) (
    input  logic           clk_i,
    input  logic           rst_ni,
    input  logic           flush_i,
    input  logic [63:0]    vpc_i,
    output logic           predict_valid_o,
    output logic           predict_taken_o,
    output logic [63:0]    predict_address_o,
    output logic           predict_lower_16_o,
    input  branchpredict_t resolved_branch_i,
    output logic           flush_busy_o
);

    localparam int               c_IDX      = $clog2(NR_ENTRIES);
    localparam logic [0:0]       c_ST_IDLE  = 1'b0;
    localparam logic [0:0]       c_ST_SWEEP = 1'b1;
    localparam logic [c_IDX-1:0] c_LAST_IDX = c_IDX'(NR_ENTRIES - 1);

    logic [0:0]          r_state;
    logic [0:0]          w_state_next;
    logic [c_IDX-1:0]    r_sweep_idx;
    logic [c_IDX-1:0]    w_sweep_idx_next;
    logic                w_sweeping;

    logic [NR_ENTRIES-1:0] r_valid;
    logic [1:0]            r_ctr    [NR_ENTRIES];
    logic [TAG_BITS-1:0]   r_tag    [NR_ENTRIES];
    logic [63:0]           r_target [NR_ENTRIES];
    logic [NR_ENTRIES-1:0] r_lower_16;

    logic [c_IDX-1:0]    w_lk_idx;
    logic [TAG_BITS-1:0] w_lk_tag;
    logic                w_lk_hit;

    logic [c_IDX-1:0]    w_up_idx;
    logic [TAG_BITS-1:0] w_up_tag;
    logic                w_up_en;
    logic                w_up_hit;
    logic                w_up_write;
    logic [1:0]          w_ctr_next;

    // ------------------------------------------------------------------
    // Flush FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state     <= c_ST_IDLE;
            r_sweep_idx <= '0;
        end else begin
            r_state     <= w_state_next;
            r_sweep_idx <= w_sweep_idx_next;
        end
    end

    always_comb begin
        w_state_next     = r_state;
        w_sweep_idx_next = r_sweep_idx;
        case (r_state)
            c_ST_IDLE: begin
                if (flush_i) begin
                    w_state_next     = c_ST_SWEEP;
                    w_sweep_idx_next = '0;
                end
            end
            c_ST_SWEEP: begin
                if (flush_i) begin
                    w_sweep_idx_next = '0;
                end else if (r_sweep_idx == c_LAST_IDX) begin
                    w_state_next     = c_ST_IDLE;
                    w_sweep_idx_next = '0;
                end else begin
                    w_sweep_idx_next = r_sweep_idx + c_IDX'(1);
                end
            end
            default: begin
                w_state_next     = c_ST_IDLE;
                w_sweep_idx_next = '0;
            end
        endcase
    end

    always_comb begin
        w_sweeping   = (r_state == c_ST_SWEEP);
        flush_busy_o = w_sweeping;
    end

    // ------------------------------------------------------------------
    // Lookup: reads pre-update contents, suppressed while sweeping
    // ------------------------------------------------------------------
    assign w_lk_idx = vpc_i[c_IDX:1];
    assign w_lk_tag = vpc_i[c_IDX+TAG_BITS:c_IDX+1];
    assign w_lk_hit = r_valid[w_lk_idx] && (r_tag[w_lk_idx] == w_lk_tag) && !w_sweeping;

    assign predict_valid_o    = w_lk_hit;
    assign predict_taken_o    = w_lk_hit && r_ctr[w_lk_idx][1];
    assign predict_address_o  = w_lk_hit ? r_target[w_lk_idx] : 64'd0;
    assign predict_lower_16_o = w_lk_hit && r_lower_16[w_lk_idx];

    // ------------------------------------------------------------------
    // Update from execute
    // ------------------------------------------------------------------
    assign w_up_idx   = resolved_branch_i.pc[c_IDX:1];
    assign w_up_tag   = resolved_branch_i.pc[c_IDX+TAG_BITS:c_IDX+1];
    assign w_up_en    = rst_ni && resolved_branch_i.valid && !w_sweeping && !flush_i;
    assign w_up_hit   = r_valid[w_up_idx] && (r_tag[w_up_idx] == w_up_tag);
    // Hit-and-taken rewrites the same tag, miss-and-taken allocates: both write payload.
    assign w_up_write = w_up_en && !resolved_branch_i.clear && resolved_branch_i.is_taken;

    always_comb begin
        w_ctr_next = r_ctr[w_up_idx];
        if (resolved_branch_i.is_taken) begin
            if (r_ctr[w_up_idx] != 2'b11) w_ctr_next = r_ctr[w_up_idx] + 2'd1;
        end else begin
            if (r_ctr[w_up_idx] != 2'b00) w_ctr_next = r_ctr[w_up_idx] - 2'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_valid <= '0;
            for (int i = 0; i < NR_ENTRIES; i++) begin
                r_ctr[i] <= 2'b00;
            end
        end else begin
            if (w_sweeping) begin
                r_valid[r_sweep_idx] <= 1'b0;
            end
            if (w_up_en) begin
                if (resolved_branch_i.clear) begin
                    r_valid[w_up_idx] <= 1'b0;
                end else if (w_up_hit) begin
                    r_ctr[w_up_idx] <= w_ctr_next;
                end else if (resolved_branch_i.is_taken) begin
                    r_valid[w_up_idx] <= 1'b1;
                    r_ctr[w_up_idx]   <= 2'b10;
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_up_write) begin
            r_tag[w_up_idx]      <= w_up_tag;
            r_target[w_up_idx]   <= resolved_branch_i.target_address;
            r_lower_16[w_up_idx] <= resolved_branch_i.is_lower_16;
        end
    end

    // Bits outside index/tag and the mispredict flag do not influence the table.
    logic w_unused;
    assign w_unused = ^{vpc_i[63:c_IDX+TAG_BITS+1], vpc_i[0],
                        resolved_branch_i.pc[63:c_IDX+TAG_BITS+1], resolved_branch_i.pc[0],
                        resolved_branch_i.is_mispredict};

endmodule

`default_nettype wire

// File: tb/tb_btb.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_btb
//  Brief    : Directed and randomized checks of btb against a table model.
//  Revision : 1.0
// ============================================================================

module tb_btb;
    import btb_pkg::*;

    localparam int N   = 64;
    localparam int TB  = 16;
    localparam int IDX = 6;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           flush;
    logic [63:0]    vpc;
    branchpredict_t br;
    logic           pv, pt, pl, busy;
    logic [63:0]    pa;

    always #5 clk = ~clk;

    btb #(.NR_ENTRIES(N), .TAG_BITS(TB)) dut (
        .clk_i              (clk),
        .rst_ni             (rst_n),
        .flush_i            (flush),
        .vpc_i              (vpc),
        .predict_valid_o    (pv),
        .predict_taken_o    (pt),
        .predict_address_o  (pa),
        .predict_lower_16_o (pl),
        .resolved_branch_i  (br),
        .flush_busy_o       (busy)
    );

    // Reference table
    bit            m_valid [N];
    logic [TB-1:0] m_tag   [N];
    logic [63:0]   m_tgt   [N];
    bit            m_l16   [N];
    int            m_ctr   [N];
    int            sweep_left;

    int   n_checks = 0;
    int   n_pass   = 0;
    logic obs_busy;
    int   busy_cnt;

    task automatic check(input string name, input logic [67:0] obs, input logic [67:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", name, obs, exp);
    endtask

    function automatic int idx_of(input logic [63:0] pc);
        return int'((pc >> 1) % N);
    endfunction

    function automatic logic [TB-1:0] tag_of(input logic [63:0] pc);
        return TB'((pc >> (IDX + 1)) % (64'd1 << TB));
    endfunction

    // Packed as {valid, taken, lower_16, busy, address}
    function automatic logic [67:0] model_out(input logic [63:0] pc);
        int i = idx_of(pc);
        if (sweep_left == 0 && m_valid[i] && m_tag[i] == tag_of(pc))
            return {1'b1, m_ctr[i] >= 2, m_l16[i], 1'b0, m_tgt[i]};
        return {3'b000, sweep_left > 0, 64'd0};
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < N; i++) begin
            m_valid[i] = 0;
            m_ctr[i]   = 0;
        end
        sweep_left = 0;
    endfunction

    function automatic void model_edge(input logic r, input logic f, input branchpredict_t b);
        int i;
        logic [TB-1:0] t;
        if (!r) begin
            model_reset();
            return;
        end
        if (sweep_left > 0) begin
            m_valid[N - sweep_left] = 0;
            sweep_left = f ? N : sweep_left - 1;
        end else if (f) begin
            sweep_left = N;
        end else if (b.valid) begin
            i = idx_of(b.pc);
            t = tag_of(b.pc);
            if (b.clear) begin
                m_valid[i] = 0;
            end else if (m_valid[i] && m_tag[i] == t) begin
                if (b.is_taken) begin
                    m_ctr[i] = (m_ctr[i] == 3) ? 3 : m_ctr[i] + 1;
                    m_tgt[i] = b.target_address;
                    m_l16[i] = b.is_lower_16;
                end else begin
                    m_ctr[i] = (m_ctr[i] == 0) ? 0 : m_ctr[i] - 1;
                end
            end else if (b.is_taken) begin
                m_valid[i] = 1;
                m_tag[i]   = t;
                m_tgt[i]   = b.target_address;
                m_l16[i]   = b.is_lower_16;
                m_ctr[i]   = 2;
            end
        end
    endfunction

    function automatic branchpredict_t mk(input logic [63:0] pc, input logic [63:0] tgt,
                                          input logic taken, input logic l16,
                                          input logic clr, input logic vld);
        branchpredict_t b;
        b.pc             = pc;
        b.target_address = tgt;
        b.is_taken       = taken;
        b.valid          = vld;
        b.is_mispredict  = 1'($urandom % 2);
        b.is_lower_16    = l16;
        b.clear          = clr;
        return b;
    endfunction

    function automatic logic [63:0] rand_pc();
        logic [63:0] p = 64'h8000_0000;
        p = p + (64'($urandom % 4) << 7) + (64'($urandom % 8) << 1) + 64'($urandom % 2);
        p = p + (64'($urandom % 2) << 40);
        return p;
    endfunction

    // One clock cycle: drive mid-low-phase, compare lookup before the edge, advance model at the edge
    task automatic step(input string name, input logic r, input logic f,
                        input branchpredict_t b, input logic [63:0] pc);
        @(negedge clk);
        rst_n = r;
        flush = f;
        br    = b;
        vpc   = pc;
        #1;
        obs_busy = busy;
        check(name, {pv, pt, pl, busy, pa}, model_out(pc));
        @(posedge clk);
        model_edge(r, f, b);
    endtask

    task automatic expect_out(input string name, input logic [67:0] exp);
        #1;
        check(name, {pv, pt, pl, busy, pa}, exp);
    endtask

    task automatic fill_table(input int count);
        for (int i = 0; i < count; i++)
            step("fill", 1'b1, 1'b0,
                 mk(64'h8000_0000 + 64'(2 * i), {32'h4000_0000, $urandom}, 1'b1, 1'($urandom % 2), 1'b0, 1'b1),
                 64'h8000_0000 + 64'(2 * i));
    endtask

    initial begin
        rst_n = 1'b0;
        flush = 1'b0;
        br    = '0;
        vpc   = 64'd0;
        repeat (3) @(posedge clk);
        model_reset();
        @(negedge clk);
        #1;
        check("reset_outputs", {pv, pt, pl, busy, pa}, 68'd0);

        // Taken allocate: invisible same cycle, visible next cycle
        step("taken_same_cycle", 1'b1, 1'b0,
             mk(64'h8000_0010, 64'h8000_0100, 1'b1, 1'b0, 1'b0, 1'b1), 64'h8000_0010);
        expect_out("taken_next_cycle", {1'b1, 1'b1, 1'b0, 1'b0, 64'h8000_0100});

        // Saturate up, then down; target held by not-taken updates
        for (int k = 0; k < 2; k++)
            step("sat_up", 1'b1, 1'b0,
                 mk(64'h8000_0010, 64'h8000_0100, 1'b1, 1'b0, 1'b0, 1'b1), 64'h8000_0010);
        for (int k = 0; k < 4; k++) begin
            step("sat_down", 1'b1, 1'b0,
                 mk(64'h8000_0010, 64'hDEAD_0000, 1'b0, 1'b1, 1'b0, 1'b1), 64'h8000_0010);
            expect_out("sat_down_after", {1'b1, k == 0, 1'b0, 1'b0, 64'h8000_0100});
        end

        // Clear through an aliasing PC
        step("alias_clear", 1'b1, 1'b0,
             mk(64'h9000_0010, 64'd0, 1'b0, 1'b0, 1'b1, 1'b1), 64'h8000_0010);
        expect_out("alias_cleared", 68'd0);

        // Not-taken miss does not allocate
        step("nt_miss", 1'b1, 1'b0,
             mk(64'h8000_0020, 64'h1234, 1'b0, 1'b0, 1'b0, 1'b1), 64'h8000_0020);
        expect_out("nt_miss_invalid", 68'd0);

        // Full flush with an update dropped mid-sweep
        fill_table(N);
        step("flush_pulse", 1'b1, 1'b1, '0, 64'h8000_0000);
        busy_cnt = 0;
        for (int c = 0; c < N + 6; c++) begin
            step("sweep", 1'b1, 1'b0,
                 (c == 20) ? mk(64'h8000_0006, 64'h55, 1'b1, 1'b0, 1'b0, 1'b1) : '0,
                 64'h8000_0000 + 64'(2 * (c % N)));
            if (obs_busy === 1'b1) busy_cnt++;
        end
        check("flush_busy_cycles", 68'(busy_cnt), 68'(N));
        for (int i = 0; i < N; i++)
            step("post_flush_empty", 1'b1, 1'b0, '0, 64'h8000_0000 + 64'(2 * i));

        // Restart sweep at cycle 30
        fill_table(N);
        step("flush_pulse2", 1'b1, 1'b1, '0, 64'h8000_0000);
        for (int c = 0; c < 30; c++)
            step("sweep2", 1'b1, 1'b0, '0, 64'h8000_0000 + 64'(2 * c));
        step("flush_restart", 1'b1, 1'b1, '0, 64'h8000_0000);
        busy_cnt = 0;
        for (int c = 0; c < N + 6; c++) begin
            step("sweep_restart", 1'b1, 1'b0, '0, 64'h8000_0000 + 64'(2 * (c % N)));
            if (obs_busy === 1'b1) busy_cnt++;
        end
        check("restart_busy_cycles", 68'(busy_cnt), 68'(N));

        // Reset mid-sweep
        fill_table(8);
        step("flush_pulse3", 1'b1, 1'b1, '0, 64'h8000_0000);
        for (int c = 0; c < 10; c++)
            step("sweep3", 1'b1, 1'b0, '0, 64'h8000_0000);
        step("rst_mid_sweep", 1'b0, 1'b1,
             mk(64'h8000_0004, 64'h77, 1'b1, 1'b0, 1'b0, 1'b1), 64'h8000_0004);
        expect_out("after_rst_idle", 68'd0);
        for (int i = 0; i < 8; i++)
            step("after_rst_empty", 1'b1, 1'b0, '0, 64'h8000_0000 + 64'(2 * i));

        // Randomized traffic
        for (int s = 0; s < 3000; s++) begin
            step("random", ($urandom % 400) != 0, ($urandom % 200) == 0,
                 mk(rand_pc(), {$urandom, $urandom}, 1'($urandom % 2), 1'($urandom % 2),
                    ($urandom % 10) == 0, ($urandom % 10) < 7),
                 rand_pc());
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
